beam_scan_controller: RTL

BEAM_SCAN_CONTROLLER -- requirements
Module: beam_scan_controller

---
 rtl/beam_scan_controller_pkg.sv | 21 ++
 rtl/beam_energy_acc.sv | 38 +++
 rtl/beam_scan_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/beam_scan_controller_pkg.sv
// Shared definitions for the beam scan controller and the delay module it steers.
// Holds the FSM encoding, the delay_select width and the accumulator width rule.
package beam_scan_controller_pkg;

    localparam int DSEL_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        DWELL   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } scan_state_t;

    // A square of a signed BEAM_W value needs at most 2*BEAM_W-1 unsigned bits;
    // summing 2^DWELL_LOG2 of them needs DWELL_LOG2 more, so this width never wraps.
    function automatic int acc_width(input int beam_w, input int dwell_log2);
        return 2 * beam_w + dwell_log2;
    endfunction

endpackage

// File: rtl/beam_energy_acc.sv
// Square-and-accumulate energy integrator for one steering direction.
// clr has priority over en; the accumulator is cleared while the controller settles.
module beam_energy_acc
    import beam_scan_controller_pkg::*;
#(
    parameter int BEAM_W     = 22,
    parameter int DWELL_LOG2 = 8,
    localparam int ACC_W     = acc_width(BEAM_W, DWELL_LOG2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [BEAM_W-1:0] beam_data,
    output logic [ACC_W-1:0]         acc
);

    logic signed [2*BEAM_W-1:0] prod_p0;
    logic [2*BEAM_W-1:0]        sq_p0;

    // The most negative input squares to 2^(2*BEAM_W-2), still positive in 2*BEAM_W signed bits.
    always_comb begin
        prod_p0 = beam_data * beam_data;
        sq_p0   = unsigned'(prod_p0);
    end

    // stage p0 -> accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(sq_p0);
        end
    end

endmodule

// File: rtl/beam_scan_controller.sv
// Scans NUM_DIRS steering directions, integrates beam energy in each and commits
// the loudest direction and its energy once per completed scan.
module beam_scan_controller
    import beam_scan_controller_pkg::*;
#(
    parameter int NUM_DIRS       = 4,
    parameter int BEAM_W         = 22,
    parameter int SETTLE_SAMPLES = 20,
    parameter int DWELL_LOG2     = 8,
    localparam int ACC_W         = acc_width(BEAM_W, DWELL_LOG2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     continuous,
    input  logic                     sample_valid,
    input  logic signed [BEAM_W-1:0] beam_data,
    output logic [DSEL_W-1:0]        delay_select,
    output logic                     scan_busy,
    output logic                     scan_done,
    output logic [DSEL_W-1:0]        best_dir,
    output logic [ACC_W-1:0]         best_energy
);

    localparam int DWELL_N = 1 << DWELL_LOG2;
    localparam int CNT_MAX = (SETTLE_SAMPLES > DWELL_N) ? SETTLE_SAMPLES : DWELL_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL_N - 1);
    localparam logic [DSEL_W-1:0] IDX_LAST    = DSEL_W'(NUM_DIRS - 1);

    scan_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DSEL_W-1:0] idx;
    logic [DSEL_W-1:0] dsel_nxt;
    logic [DSEL_W-1:0] run_dir;
    logic [ACC_W-1:0]  run_energy;
    logic [ACC_W-1:0]  acc;
    logic              cnt_clr, cnt_inc, idx_clr, idx_inc;
    logic              acc_clr, acc_en, load_run, commit;

    beam_energy_acc #(
        .BEAM_W     (BEAM_W),
        .DWELL_LOG2 (DWELL_LOG2)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .en        (acc_en),
        .beam_data (beam_data),
        .acc       (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        acc_clr   = (state == SETTLE);
        acc_en    = 1'b0;
        load_run  = 1'b0;
        commit    = 1'b0;
        dsel_nxt  = delay_select;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SETTLE;
                    idx_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (sample_valid) begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = DWELL;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (sample_valid) begin
                    acc_en = 1'b1;
                    if (cnt == DWELL_LAST) begin
                        state_nxt = COMPARE;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            COMPARE: begin
                // Strict greater-than keeps the lower index on ties.
                load_run = (idx == '0) || (acc > run_energy);
                if (idx == IDX_LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                    idx_inc   = 1'b1;
                    dsel_nxt  = idx + DSEL_W'(1);
                end
            end
            DONE: begin
                commit = 1'b1;
                if (continuous) begin
                    state_nxt = SETTLE;
                    idx_clr   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    dsel_nxt  = run_dir;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (idx_clr) dsel_nxt = '0;

        // Abort drops every partial result and steers back to the committed best.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
            cnt_inc   = 1'b0;
            idx_clr   = 1'b1;
            idx_inc   = 1'b0;
            acc_en    = 1'b0;
            load_run  = 1'b0;
            commit    = 1'b0;
            dsel_nxt  = best_dir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            idx          <= '0;
            delay_select <= '0;
            run_dir      <= '0;
            run_energy   <= '0;
            best_dir     <= '0;
            best_energy  <= '0;
            scan_done    <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);

            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + DSEL_W'(1);

            delay_select <= dsel_nxt;

            if (load_run) begin
                run_dir    <= idx;
                run_energy <= acc;
            end

            if (commit) begin
                best_dir    <= run_dir;
                best_energy <= run_energy;
            end
            scan_done <= commit;
        end
    end

    assign scan_busy = (state != IDLE);

endmodule
